// File: rtl/mem_arbiter.sv
// mem_arbiter: puts the datapath's fetch port (i_*) and data port (d_*) onto
// one single-ported, variable-latency memory bus (m_*), one transaction at a
// time.
//
// Features:
//   - Round-robin arbitration when both ports request in the same cycle.
//   - Misaligned fetches are rejected without touching memory.
//   - A response timeout, so a dead slave cannot hang the core.
//
// Ports:
//   clk, nrst                      clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt          fetch request; grant is combinational
//   i_rvalid/i_rdata/i_err         fetch response, one-cycle pulse
//   d_req/d_we/d_be/d_addr/d_wdata data request -> d_gnt (combinational)
//   d_rvalid/d_rdata/d_err         data response (loads and stores)
//   m_req/m_we/m_be/m_addr/m_wdata memory request, held until m_ack
//   m_ack/m_rdata                  memory completion and read data
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR, RESP} state_t;

    state_t            state, nxt;
    logic              owner;       // 0 = fetch, 1 = data
    logic              last_owner;  // 0 = fetch, 1 = data
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              gnt_i, gnt_d;
    logic              tmo;

    assign tmo = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        nxt   = state;
        case (state)
            IDLE: begin
                // On conflict, the port that did not win last time gets it.
                if (i_req && (!d_req || last_owner))
                    gnt_i = 1'b1;
                else if (d_req)
                    gnt_d = 1'b1;
                if (gnt_i)
                    nxt = (i_addr[1:0] != 2'b00) ? ERR : BUSY;
                else if (gnt_d)
                    nxt = BUSY;
            end
            BUSY:    if (m_ack || tmo) nxt = RESP;
            ERR:     nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            owner      <= 1'b0;
            last_owner <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (gnt_i) begin
                owner      <= 1'b0;
                last_owner <= 1'b0;
                addr_q     <= i_addr;
                we_q       <= 1'b0;
                be_q       <= '1;
                wdata_q    <= '0;
            end else if (gnt_d) begin
                owner      <= 1'b1;
                last_owner <= 1'b1;
                addr_q     <= d_addr;
                we_q       <= d_we;
                be_q       <= d_be;
                wdata_q    <= d_wdata;
            end
            case (state)
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // An ack in the timeout cycle still counts as success.
                    if (m_ack) begin
                        rdata_q <= we_q ? '0 : m_rdata;
                        err_q   <= 1'b0;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ERR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
                RESP:    cnt <= '0;
                default: ;
            endcase
        end
    end

    // Grants are gated by nrst so that they are low while reset is held.
    assign i_gnt = gnt_i & nrst;
    assign d_gnt = gnt_d & nrst;

    assign m_req   = (state == BUSY);
    assign m_we    = m_req & we_q;
    assign m_be    = m_req ? be_q    : '0;
    assign m_addr  = m_req ? addr_q  : '0;
    assign m_wdata = m_req ? wdata_q : '0;

    assign i_rvalid = (state == RESP) & ~owner;
    assign d_rvalid = (state == RESP) &  owner;
    assign i_rdata  = i_rvalid ? rdata_q : '0;
    assign d_rdata  = d_rvalid ? rdata_q : '0;
    assign i_err    = i_rvalid & err_q;
    assign d_err    = d_rvalid & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (TIMEOUT=4). The table drives single transactions;
// the conflict and reset corner cases are written out as hand sequences.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_idx;   // m_req cycle (0-based) that gets m_ack; -1 = never
        logic [31:0] mem;
        int          exp_cyc;   // cycle of rvalid, grant = cycle 0
        int          exp_mreq;  // number of m_req cycles
        logic [31:0] exp_rdata;
        bit          exp_err;
        logic [3:0]  exp_mbe;
        logic [31:0] exp_mwd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   nmreq;
        int   cyc_got;
        bit   mbad;
        bit   obad;
        bit   done;
        logic [31:0] rd;
        logic er;
        nmreq = 0; cyc_got = -1; mbad = 0; obad = 0; done = 0; rd = '0; er = 0;
        m_rdata = v.mem;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1; i_addr = v.addr;
        end
        @(negedge clk);
        chk($sformatf("v%0d own_gnt", idx), {31'd0, v.is_d ? d_gnt : i_gnt}, 32'd1);
        chk($sformatf("v%0d other_gnt", idx), {31'd0, v.is_d ? i_gnt : d_gnt}, 32'd0);
        @(posedge clk); #1;
        // Fields may change after the grant cycle; scramble them.
        i_req = 0; d_req = 0; i_addr = '1; d_addr = '1; d_wdata = '1;
        d_be = 4'h0; d_we = ~d_we;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (m_req) begin
                if (m_addr !== v.addr || m_we !== (v.is_d & v.we) ||
                    m_be !== v.exp_mbe || m_wdata !== v.exp_mwd) mbad = 1;
                if (nmreq == v.ack_idx) m_ack = 1;
                nmreq++;
            end
            if (i_gnt || d_gnt) mbad = 1;
            if (v.is_d ? i_rvalid : d_rvalid) obad = 1;
            if (v.is_d ? d_rvalid : i_rvalid) begin
                cyc_got = c;
                rd = v.is_d ? d_rdata : i_rdata;
                er = v.is_d ? d_err : i_err;
                done = 1;
            end
            @(posedge clk); #1;
            m_ack = 0;
        end
        chk($sformatf("v%0d rvalid_cycle", idx), cyc_got, v.exp_cyc);
        chk($sformatf("v%0d mreq_cycles", idx), nmreq, v.exp_mreq);
        chk($sformatf("v%0d mbus_fields", idx), {31'd0, mbad}, 32'd0);
        chk($sformatf("v%0d other_rvalid", idx), {31'd0, obad}, 32'd0);
        chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.exp_err});
    endtask

    // Both ports request continuously with zero-wait memory; record ngr grants.
    task automatic conflict(input int ngr, input string tag);
        bit   gseq[8];
        int   ng;
        bit   cur;
        bit   bad;
        bit   waiting;
        ng = 0; cur = 0; bad = 0; waiting = 0;
        m_rdata = 32'h0000_0077;
        @(posedge clk); #1;
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_addr = 32'h80; d_we = 0; d_be = 4'hF; d_wdata = 32'h0;
        for (int c = 0; c < 40 && (ng < ngr || waiting); c++) begin
            @(negedge clk);
            m_ack = m_req;
            if ((i_gnt && i_rvalid) || (d_gnt && d_rvalid) || (i_gnt && d_gnt)) bad = 1;
            if (m_req && m_addr !== (cur ? 32'h80 : 32'h40)) bad = 1;
            if (i_rvalid || d_rvalid) begin
                if (!waiting || d_rvalid !== cur || i_rvalid !== ~cur) bad = 1;
                waiting = 0;
            end
            if (i_gnt || d_gnt) begin
                cur = d_gnt;
                gseq[ng] = d_gnt;
                ng++;
                waiting = 1;
                if (ng == ngr) begin
                    @(posedge clk); #1;
                    i_req = 0; d_req = 0;
                end
            end
        end
        m_ack = 0;
        chk({tag, " grant_count"}, ng, ngr);
        for (int k = 0; k < ngr; k++)
            chk($sformatf("%s grant%0d_is_d", tag, k), {31'd0, gseq[k]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        chk({tag, " owner_routing"}, {31'd0, bad}, 32'd0);
        chk({tag, " final_idle"}, {31'd0, waiting}, 32'd0);
    endtask

    initial begin
        //            is_d we be    addr          wdata         ack mem           cyc mreq rdata         err mbe   mwd
        vecs[0] = '{0, 0, 4'hF, 32'h0000_0100, 32'h0,        2, 32'hDEADBEEF, 4, 3, 32'hDEADBEEF, 0, 4'hF, 32'h0};
        vecs[1] = '{1, 1, 4'h3, 32'h0000_2000, 32'h1234ABCD, 1, 32'h55555555, 3, 2, 32'h0,        0, 4'h3, 32'h1234ABCD};
        vecs[2] = '{1, 0, 4'hF, 32'h0000_3004, 32'h0,        0, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 0, 4'hF, 32'h0};
        vecs[3] = '{1, 0, 4'hF, 32'h0000_3008, 32'h0,       -1, 32'h99999999, 5, 4, 32'h0,        1, 4'hF, 32'h0};
        vecs[4] = '{1, 0, 4'hF, 32'h0000_300C, 32'h0,        0, 32'h01234567, 2, 1, 32'h01234567, 0, 4'hF, 32'h0};
        vecs[5] = '{1, 0, 4'hF, 32'h0000_3010, 32'h0,        3, 32'hA5A5A5A5, 5, 4, 32'hA5A5A5A5, 0, 4'hF, 32'h0};
        vecs[6] = '{0, 0, 4'hF, 32'h0000_0102, 32'h0,        0, 32'h0,        2, 0, 32'h0,        1, 4'hF, 32'h0};
        vecs[7] = '{0, 0, 4'hF, 32'h0000_0104, 32'h0,        0, 32'h11112222, 2, 1, 32'h11112222, 0, 4'hF, 32'h0};
        vecs[8] = '{1, 1, 4'h1, 32'h0000_2001, 32'h000000EE, 0, 32'hFFFFFFFF, 2, 1, 32'h0,        0, 4'h1, 32'h000000EE};
        vecs[9] = '{1, 1, 4'hC, 32'h0000_2004, 32'hABCD0000,-1, 32'h0,        5, 4, 32'h0,        1, 4'hC, 32'hABCD0000};

        nrst = 0; i_req = 1; i_addr = 32'h0; d_req = 0; d_we = 0; d_be = 4'h0;
        d_addr = 32'h0; d_wdata = 32'h0; m_ack = 0; m_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst i_gnt", {31'd0, i_gnt}, 32'd0);
        chk("rst m_req", {31'd0, m_req}, 32'd0);
        chk("rst rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        chk("rst m_addr", m_addr, 32'h0);
        i_req = 0;
        nrst = 1;

        conflict(4, "conf");

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // m_ack with no outstanding request must be ignored.
        @(posedge clk); #1; m_ack = 1;
        @(posedge clk); #1; m_ack = 0;
        @(negedge clk);
        chk("stray_ack rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);

        // Reset while BUSY.
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h500;
        @(posedge clk); #1;
        d_req = 0;
        @(negedge clk);
        chk("midrst m_req_before", {31'd0, m_req}, 32'd1);
        #2 nrst = 0; i_req = 1;
        #1;
        chk("midrst m_req", {31'd0, m_req}, 32'd0);
        chk("midrst gnts", {30'd0, i_gnt, d_gnt}, 32'd0);
        chk("midrst rvalids", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        repeat (2) @(negedge clk);
        i_req = 0;
        nrst = 1;
        run_vec(vecs[0], 100);
        conflict(2, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the datapath's instruction-fetch port and data port onto one single-ported, variable-latency memory bus.
- Sits directly downstream of the datapath: the datapath issues requests, this block serialises them to memory and returns responses.
- One transaction outstanding at a time.
- Provides round-robin fairness on conflict, misaligned-fetch rejection, and a response timeout so a dead slave cannot hang the core.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables are DATA_W/8 wide)
TIMEOUT, 255, max cycles waiting for m_ack before an error response; must be ≥1

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
i_req  in  1  fetch request
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted this cycle (combinational)
i_rvalid  out  1  fetch response valid, 1-cycle pulse
i_rdata  out  DATA_W  fetch data
i_err  out  1  fetch error (misaligned or timeout), qualified by i_rvalid
d_req  in  1  data request
d_we  in  1  1=store, 0=load
d_be  in  DATA_W/8  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  data response valid, 1-cycle pulse
d_rdata  out  DATA_W  load data
d_err  out  1  data error (timeout), qualified by d_rvalid
m_req  out  1  memory request, held until m_ack
m_we  out  1  memory write
m_be  out  DATA_W/8  memory byte enables
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_ack  in  1  memory completion; m_rdata valid this cycle
m_rdata  in  DATA_W  memory read data

Behaviour:
- Clocking/reset: single clock clk; asynchronous active-low reset nrst.
- Reset values: all outputs 0; FSM=IDLE; last_owner=I; timeout counter 0. Reset mid-transaction aborts it with no response, and m_req drops immediately.
- FSM states:
  - IDLE: grant is combinational.
    - Only one of i_req/d_req high: grant it.
    - Both high: grant D if last_owner==I, else grant I; update last_owner on every grant. The first conflict after reset therefore goes to D.
    - On grant, latch addr/we/be/wdata (fetch: we=0, be=all-ones). Next state is BUSY, or ERR for a misaligned fetch.
    - The requester must hold its fields stable only in the grant cycle.
  - BUSY: m_req=1, m_* driven from the latched registers and stable until m_ack.
    - Counter increments each BUSY cycle.
    - m_ack=1: latch m_rdata (write: rdata=0), err=0, go to RESP.
    - Counter reaches TIMEOUT without ack: rdata=0, err=1, m_req deasserts next cycle, go to RESP. If m_ack arrives in the timeout cycle, the ack wins.
  - ERR: misaligned fetch (i_addr[1:0]!=0). No memory access; rdata=0, err=1; go to RESP.
  - RESP: owner's rvalid=1 for exactly one cycle with the latched rdata/err; the other port's rvalid=0. Clear the counter; go to IDLE. No grants in RESP.
- Latency:
  - Grant at cycle 0, m_req first high at cycle 1.
  - m_ack at cycle k gives rvalid at k+1; next grant possible at k+2.
  - Zero-wait memory (ack at cycle 1): rvalid at cycle 2, throughput 1 transaction per 3 cycles.
  - Misaligned fetch: rvalid+err at cycle 2.
- Loads and stores both return a d_rvalid completion.
- Data misalignment is not checked here; it is the datapath's responsibility.
- gnt never asserts outside IDLE. rvalid and gnt are never simultaneously high for the same port.
- m_ack while m_req=0 is ignored.

Test Plan:
- Single fetch: i_req, i_addr=0x100; memory acks 2 cycles after m_req with 0xDEADBEEF -> i_gnt at c0; m_req c1–c3 with m_addr=0x100, m_we=0, m_be=0xF; i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0 at c4.
- Conflict fairness: i_req and d_req held high continuously, zero-wait memory -> grants D, I, D, I in order; each rvalid goes only to its owner; last_owner alternates.
- Store: d_we=1, d_be=0x3, d_addr=0x2000, d_wdata=0x1234ABCD -> m_we=1, m_be=0x3, m_wdata=0x1234ABCD held stable until ack; d_rvalid=1, d_rdata=0, d_err=0.
- Timeout: TIMEOUT=4, no m_ack -> m_req high exactly 4 cycles, then d_rvalid=1, d_err=1, d_rdata=0; a following request completes normally. Variant: ack in the 4th cycle -> err=0.
- Misaligned fetch: i_addr=0x102 -> m_req never asserts; i_rvalid=1, i_err=1 at c2.
- Reset mid-BUSY: assert nrst=0 while m_req=1 -> m_req, all rvalids and gnts drop asynchronously; after release, a fetch completes normally and the first conflict grants D.
